// File: rtl/controle_multiciclo.sv
// Multicycle MIPS control FSM: decodes one instruction per handshake
// and sequences FETCH/DECODE/EXEC/MEM/WB, driving ALU and datapath strobes.
module controle_multiciclo #(
    parameter int ILLEGAL_HALT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic        zero_flag,
    output logic [3:0]  alu_op,
    output logic [4:0]  shamt,
    output logic [15:0] immediate,
    output logic        bne,
    output logic        alu_src_imm,
    output logic        reg_dst_rd,
    output logic        reg_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        mem_to_reg,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        illegal,
    output logic        done
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        K_R, K_ALUI, K_LW, K_SW, K_BR, K_J, K_ILL
    } kind_t;

    state_t      r_state;
    state_t      w_next;
    kind_t       r_kind;
    logic [31:0] r_instr;
    logic [3:0]  r_alu_op;
    logic        r_alu_src_imm;
    logic        r_bne;

    kind_t       w_kind;
    logic [3:0]  w_alu_op;
    logic        w_src_imm;
    logic        w_bne;
    logic        w_illegal;
    logic [5:0]  w_opc;
    logic [5:0]  w_fn;
    logic        w_halt;

    assign w_opc     = r_instr[31:26];
    assign w_fn      = r_instr[5:0];
    assign w_illegal = (w_kind == K_ILL);
    assign w_halt    = (ILLEGAL_HALT != 0);

    assign shamt       = r_instr[10:6];
    assign immediate   = r_instr[15:0];
    assign alu_op      = r_alu_op;
    assign alu_src_imm = r_alu_src_imm;

    // Decode opcode/funct of the latched instruction into class and ALU controls
    always_comb begin
        w_kind    = K_ILL;
        w_alu_op  = 4'b0000;
        w_src_imm = 1'b0;
        w_bne     = 1'b0;
        case (w_opc)
            6'h00: begin
                w_kind = K_R;
                case (w_fn)
                    6'h00:        w_alu_op = 4'b0000;
                    6'h02:        w_alu_op = 4'b0001;
                    6'h03:        w_alu_op = 4'b0010;
                    6'h04:        w_alu_op = 4'b0011;
                    6'h06:        w_alu_op = 4'b0100;
                    6'h07:        w_alu_op = 4'b0101;
                    6'h20, 6'h21: w_alu_op = 4'b0110;
                    6'h22, 6'h23: w_alu_op = 4'b0111;
                    6'h24:        w_alu_op = 4'b1000;
                    6'h25:        w_alu_op = 4'b1001;
                    6'h26:        w_alu_op = 4'b1010;
                    6'h27:        w_alu_op = 4'b1011;
                    6'h2A:        w_alu_op = 4'b1100;
                    6'h2B:        w_alu_op = 4'b1101;
                    default:      w_kind   = K_ILL;
                endcase
            end
            6'h08: begin
                w_kind    = K_ALUI;
                w_alu_op  = 4'b0110;
                w_src_imm = 1'b1;
            end
            6'h0A: begin
                w_kind    = K_ALUI;
                w_alu_op  = 4'b1100;
                w_src_imm = 1'b1;
            end
            6'h0B: begin
                w_kind    = K_ALUI;
                w_alu_op  = 4'b1101;
                w_src_imm = 1'b1;
            end
            6'h0F: begin
                w_kind   = K_ALUI;
                w_alu_op = 4'b1110;
            end
            6'h0D: begin
                // ALU takes the raw immediate for ori, so In2 stays on rt
                w_kind   = K_ALUI;
                w_alu_op = 4'b1111;
            end
            6'h23: begin
                w_kind    = K_LW;
                w_alu_op  = 4'b0110;
                w_src_imm = 1'b1;
            end
            6'h2B: begin
                w_kind    = K_SW;
                w_alu_op  = 4'b0110;
                w_src_imm = 1'b1;
            end
            6'h04: begin
                w_kind   = K_BR;
                w_alu_op = 4'b0111;
            end
            6'h05: begin
                w_kind   = K_BR;
                w_alu_op = 4'b0111;
                w_bne    = 1'b1;
            end
            6'h02: w_kind = K_J;
            default: w_kind = K_ILL;
        endcase
    end

    // State register, instruction latch and registered decode results
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_FETCH;
            r_instr       <= '0;
            r_kind        <= K_R;
            r_alu_op      <= '0;
            r_alu_src_imm <= 1'b0;
            r_bne         <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_FETCH && inst_valid) begin
                r_instr <= instruction;
            end
            if (r_state == S_DECODE) begin
                r_kind        <= w_kind;
                r_alu_op      <= w_alu_op;
                r_alu_src_imm <= w_src_imm;
                r_bne         <= w_bne;
            end
        end
    end

    // Next-state sequencing per instruction class
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (inst_valid) w_next = S_DECODE;
            S_DECODE: begin
                if (w_illegal && w_halt) w_next = S_HALT;
                else                     w_next = S_EXEC;
            end
            S_EXEC: begin
                case (r_kind)
                    K_R, K_ALUI: w_next = S_WB;
                    K_LW, K_SW:  w_next = S_MEM;
                    default:     w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (r_kind == K_LW) w_next = S_WB;
                else                w_next = S_FETCH;
            end
            S_WB:     w_next = S_FETCH;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH;
        endcase
    end

    // Per-state strobes; reset suppresses everything but inst_ready
    always_comb begin
        inst_ready = 1'b0;
        bne        = 1'b0;
        reg_dst_rd = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 2'b00;
        illegal    = 1'b0;
        done       = 1'b0;
        if (reset) begin
            inst_ready = 1'b1;
        end else begin
            case (r_state)
                S_FETCH:  inst_ready = 1'b1;
                S_DECODE: illegal    = w_illegal;
                S_EXEC: begin
                    bne = r_bne;
                    case (r_kind)
                        K_BR: begin
                            pc_write = 1'b1;
                            pc_src   = zero_flag ? 2'b01 : 2'b00;
                            done     = 1'b1;
                        end
                        K_J: begin
                            pc_write = 1'b1;
                            pc_src   = 2'b10;
                            done     = 1'b1;
                        end
                        K_ILL: begin
                            pc_write = 1'b1;
                            done     = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (r_kind == K_LW) begin
                        mem_read = 1'b1;
                    end else begin
                        mem_write = 1'b1;
                        pc_write  = 1'b1;
                        done      = 1'b1;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    reg_dst_rd = (r_kind == K_R);
                    mem_to_reg = (r_kind == K_LW);
                    pc_write   = 1'b1;
                    done       = 1'b1;
                end
                S_HALT:   illegal = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: per-cycle strobe tables
// plus hand-written illegal-instruction and reset-abort sequences.
module tb_controle_multiciclo;

    localparam logic [11:0] IR  = 12'h800;
    localparam logic [11:0] RW  = 12'h400;
    localparam logic [11:0] RD  = 12'h200;
    localparam logic [11:0] MR  = 12'h100;
    localparam logic [11:0] MW  = 12'h080;
    localparam logic [11:0] M2R = 12'h040;
    localparam logic [11:0] PW  = 12'h020;
    localparam logic [11:0] PSJ = 12'h010;
    localparam logic [11:0] PSB = 12'h008;
    localparam logic [11:0] DN  = 12'h004;
    localparam logic [11:0] BN  = 12'h002;
    localparam logic [11:0] IL  = 12'h001;

    typedef struct {
        logic [31:0] ins;
        logic        z;
        logic        ca;
        logic [3:0]  op;
        logic        si;
        logic [4:0]  sh;
        logic [15:0] im;
        logic [11:0] e0, e1, e2, e3, e4;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic        inst_valid;
    logic        zero_flag;

    logic        h_ready, h_bne, h_src, h_rd, h_rw;
    logic        h_mr, h_mw, h_m2r, h_pw, h_ill, h_done;
    logic [3:0]  h_op;
    logic [4:0]  h_sh;
    logic [15:0] h_im;
    logic [1:0]  h_ps;

    logic        n_ready, n_bne, n_src, n_rd, n_rw;
    logic        n_mr, n_mw, n_m2r, n_pw, n_ill, n_done;
    logic [3:0]  n_op;
    logic [4:0]  n_sh;
    logic [15:0] n_im;
    logic [1:0]  n_ps;

    logic [11:0] h_pk, n_pk;

    int total;
    int passed;

    controle_multiciclo #(.ILLEGAL_HALT(1)) u_h (
        .clock(clk), .reset(reset), .instruction(instruction),
        .inst_valid(inst_valid), .inst_ready(h_ready),
        .zero_flag(zero_flag), .alu_op(h_op), .shamt(h_sh),
        .immediate(h_im), .bne(h_bne), .alu_src_imm(h_src),
        .reg_dst_rd(h_rd), .reg_write(h_rw), .mem_read(h_mr),
        .mem_write(h_mw), .mem_to_reg(h_m2r), .pc_write(h_pw),
        .pc_src(h_ps), .illegal(h_ill), .done(h_done)
    );

    controle_multiciclo #(.ILLEGAL_HALT(0)) u_n (
        .clock(clk), .reset(reset), .instruction(instruction),
        .inst_valid(inst_valid), .inst_ready(n_ready),
        .zero_flag(zero_flag), .alu_op(n_op), .shamt(n_sh),
        .immediate(n_im), .bne(n_bne), .alu_src_imm(n_src),
        .reg_dst_rd(n_rd), .reg_write(n_rw), .mem_read(n_mr),
        .mem_write(n_mw), .mem_to_reg(n_m2r), .pc_write(n_pw),
        .pc_src(n_ps), .illegal(n_ill), .done(n_done)
    );

    assign h_pk = {h_ready, h_rw, h_rd, h_mr, h_mw, h_m2r,
                   h_pw, h_ps, h_done, h_bne, h_ill};
    assign n_pk = {n_ready, n_rw, n_rd, n_mr, n_mw, n_m2r,
                   n_pw, n_ps, n_done, n_bne, n_ill};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic vec_t mk(
        input logic [31:0] ins, input logic z, input logic ca,
        input logic [3:0] op, input logic si, input logic [4:0] sh,
        input logic [15:0] im, input logic [11:0] e0,
        input logic [11:0] e1, input logic [11:0] e2,
        input logic [11:0] e3, input logic [11:0] e4);
        vec_t v;
        v.ins = ins; v.z = z; v.ca = ca; v.op = op; v.si = si;
        v.sh = sh; v.im = im;
        v.e0 = e0; v.e1 = e1; v.e2 = e2; v.e3 = e3; v.e4 = e4;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        logic [11:0] ex;
        string nm;
        @(negedge clk);
        instruction = v.ins;
        inst_valid  = 1'b1;
        zero_flag   = v.z;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 1) inst_valid = 1'b0;
            #1;
            case (k)
                0: ex = v.e0;
                1: ex = v.e1;
                2: ex = v.e2;
                3: ex = v.e3;
                default: ex = v.e4;
            endcase
            nm = $sformatf("v%0d_c%0d_strobes", idx, k + 1);
            chk(nm, {20'd0, h_pk}, {20'd0, ex});
            if (k == 2) begin
                nm = $sformatf("v%0d_fields", idx);
                chk(nm, {6'd0, h_src, h_sh, h_im},
                    {6'd0, v.si, v.sh, v.im});
                if (v.ca) begin
                    nm = $sformatf("v%0d_alu_op", idx);
                    chk(nm, {28'd0, h_op}, {28'd0, v.op});
                end
            end
        end
    endtask

    vec_t tv[13];

    initial begin
        total = 0;
        passed = 0;
        reset = 1'b1;
        inst_valid = 1'b0;
        instruction = 32'h0;
        zero_flag = 1'b0;

        tv[0]  = mk(32'h00221820, 0, 1, 4'b0110, 0, 5'd0, 16'h1820,
                    IR, 0, 0, RW|RD|PW|DN, IR);
        tv[1]  = mk(32'h00011100, 0, 1, 4'b0000, 0, 5'd4, 16'h1100,
                    IR, 0, 0, RW|RD|PW|DN, IR);
        tv[2]  = mk(32'h3C011234, 0, 1, 4'b1110, 0, 5'd8, 16'h1234,
                    IR, 0, 0, RW|PW|DN, IR);
        tv[3]  = mk(32'h8C220008, 0, 1, 4'b0110, 1, 5'd0, 16'h0008,
                    IR, 0, 0, MR, RW|M2R|PW|DN);
        tv[4]  = mk(32'hAC220008, 0, 1, 4'b0110, 1, 5'd0, 16'h0008,
                    IR, 0, 0, MW|PW|DN, IR);
        tv[5]  = mk(32'h14220003, 1, 1, 4'b0111, 0, 5'd0, 16'h0003,
                    IR, 0, BN|PW|PSB|DN, IR, IR);
        tv[6]  = mk(32'h14220003, 0, 1, 4'b0111, 0, 5'd0, 16'h0003,
                    IR, 0, BN|PW|DN, IR, IR);
        tv[7]  = mk(32'h10220003, 1, 1, 4'b0111, 0, 5'd0, 16'h0003,
                    IR, 0, PW|PSB|DN, IR, IR);
        tv[8]  = mk(32'h08000010, 0, 0, 4'b0000, 0, 5'd0, 16'h0010,
                    IR, 0, PW|PSJ|DN, IR, IR);
        tv[9]  = mk(32'h20220005, 0, 1, 4'b0110, 1, 5'd0, 16'h0005,
                    IR, 0, 0, RW|PW|DN, IR);
        tv[10] = mk(32'h34220005, 0, 1, 4'b1111, 0, 5'd0, 16'h0005,
                    IR, 0, 0, RW|PW|DN, IR);
        tv[11] = mk(32'h0022182B, 0, 1, 4'b1101, 0, 5'd0, 16'h182B,
                    IR, 0, 0, RW|RD|PW|DN, IR);
        tv[12] = mk(32'h00221827, 0, 1, 4'b1011, 0, 5'd0, 16'h1827,
                    IR, 0, 0, RW|RD|PW|DN, IR);

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("reset_strobes", {20'd0, h_pk}, {20'd0, IR});
        chk("reset_fields", {h_op, h_sh, h_im, h_src}, 26'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(i, tv[i]);

        // Illegal opcode 0x3F on both halting and skipping variants
        @(negedge clk);
        instruction = 32'hFC000000;
        inst_valid  = 1'b1;
        zero_flag   = 1'b0;
        #1;
        chk("ill_c1_h", {20'd0, h_pk}, {20'd0, IR});
        @(negedge clk);
        inst_valid = 1'b0;
        #1;
        chk("ill_c2_h", {20'd0, h_pk}, {20'd0, IL});
        chk("ill_c2_n", {20'd0, n_pk}, {20'd0, IL});
        @(negedge clk);
        #1;
        chk("ill_c3_h", {20'd0, h_pk}, {20'd0, IL});
        chk("ill_c3_n", {20'd0, n_pk}, {20'd0, PW|DN});
        @(negedge clk);
        #1;
        chk("ill_c4_n", {20'd0, n_pk}, {20'd0, IR});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            instruction = 32'h00221820;
            inst_valid  = 1'b1;
            #1;
            chk($sformatf("halt_%0d", i), {20'd0, h_pk}, {20'd0, IL});
        end
        @(negedge clk);
        inst_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("halt_reset_h", {20'd0, h_pk}, {20'd0, IR});
        chk("halt_reset_n", {20'd0, n_pk}, {20'd0, IR});

        // Reset landing in the MEM cycle of lw aborts the writeback
        @(negedge clk);
        instruction = 32'h8C220008;
        inst_valid  = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("lw_mem_read", {31'd0, h_mr}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("abort_fetch", {20'd0, h_pk}, {20'd0, IR});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("idle_%0d", i), {20'd0, h_pk}, {20'd0, IR});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
